// File: rtl/timestamp_sequencer.sv
// timestamp_sequencer
// Consumer side of a ping-pong timestamp memory. It walks the active bank from
// address 0 and compares each timestamp with a tick counter that restarts at
// every pass. When an entry is due, it emits a one-cycle pulse. It also owns the
// bank selector and flips it only between passes, so the host can safely reload
// the inactive bank while a pass is running.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            begin a pass (only acted on while idle)
//   stop_i             abort the running pass
//   loop_i             restart automatically at the end of a pass
//   len_i              number of table entries (0..2^ADDR_W), latched at start
//   swap_req_i         inactive bank is loaded; swap at the next pass boundary
//   raddr_o            read address into the timestamp memory
//   timestamp_i        read data, valid RD_LAT cycles after raddr_o
//   mem_selector_o     bank selector into the timestamp memory
//   pulse_o, idx_o     event pulse and the index of the entry that fired
//   done_o             pass completed
//   swap_ack_o         selector toggled
//   busy_o             sequencer is not idle
//   late_o             sticky: some entry fired after its timestamp
module timestamp_sequencer #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              swap_req_i,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic [DATA_W-1:0] timestamp_i,
    output logic              mem_selector_o,
    output logic              pulse_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic              done_o,
    output logic              swap_ack_o,
    output logic              busy_o,
    output logic              late_o
);

    localparam int unsigned       WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = 1;
    localparam logic [ADDR_W:0]   LEN_ONE   = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [DATA_W-1:0] TICK_ONE  = 1;

    typedef enum logic [1:0] {IDLE, FETCH, ARMED} state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   len_q, len_nx;
    logic [ADDR_W-1:0] raddr_nx, idx_nx;
    logic [DATA_W-1:0] tick, tick_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              pending, pending_nx;
    logic              sel_nx, pulse_nx, done_nx, ack_nx, late_nx;
    logic              due, last;

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            len_q          <= '0;
            raddr_o        <= '0;
            idx_o          <= '0;
            tick           <= '0;
            wait_cnt       <= '0;
            pending        <= 1'b0;
            mem_selector_o <= 1'b0;
            pulse_o        <= 1'b0;
            done_o         <= 1'b0;
            swap_ack_o     <= 1'b0;
            late_o         <= 1'b0;
        end else begin
            state          <= state_nx;
            len_q          <= len_nx;
            raddr_o        <= raddr_nx;
            idx_o          <= idx_nx;
            tick           <= tick_nx;
            wait_cnt       <= wait_nx;
            pending        <= pending_nx;
            mem_selector_o <= sel_nx;
            pulse_o        <= pulse_nx;
            done_o         <= done_nx;
            swap_ack_o     <= ack_nx;
            late_o         <= late_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        len_nx     = len_q;
        raddr_nx   = raddr_o;
        idx_nx     = idx_o;
        tick_nx    = tick;
        wait_nx    = wait_cnt;
        pending_nx = pending;
        sel_nx     = mem_selector_o;
        pulse_nx   = 1'b0;
        done_nx    = 1'b0;
        ack_nx     = 1'b0;
        late_nx    = late_o;
        due        = (tick >= timestamp_i);
        last       = ({1'b0, raddr_o} == (len_q - LEN_ONE));

        case (state)
            IDLE: begin
                // A request deferred by an aborted pass is serviced here too.
                if (swap_req_i || pending) begin
                    sel_nx     = ~mem_selector_o;
                    ack_nx     = 1'b1;
                    pending_nx = 1'b0;
                end
                if (start_i) begin
                    if (len_i != '0) begin
                        len_nx   = len_i;
                        raddr_nx = '0;
                        tick_nx  = '0;
                        wait_nx  = '0;
                        late_nx  = 1'b0;
                        state_nx = FETCH;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end

            FETCH, ARMED: begin
                if (swap_req_i) begin
                    pending_nx = 1'b1;
                end
                // The counter saturates, so an entry stuck at the maximum
                // timestamp still fires instead of waiting for a wrap.
                if (tick != '1) begin
                    tick_nx = tick + TICK_ONE;
                end

                if (stop_i) begin
                    state_nx = IDLE;
                end else if (state == FETCH) begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_nx = ARMED;
                    end else begin
                        wait_nx = wait_cnt + WAIT_ONE;
                    end
                end else if (due) begin
                    pulse_nx = 1'b1;
                    idx_nx   = raddr_o;
                    if (tick != timestamp_i) begin
                        late_nx = 1'b1;
                    end
                    if (!last) begin
                        raddr_nx = raddr_o + ADDR_ONE;
                        wait_nx  = '0;
                        state_nx = FETCH;
                    end else begin
                        done_nx = 1'b1;
                        // A request arriving on this very cycle still counts.
                        if (pending || swap_req_i) begin
                            sel_nx     = ~mem_selector_o;
                            ack_nx     = 1'b1;
                            pending_nx = 1'b0;
                        end
                        if (loop_i) begin
                            raddr_nx = '0;
                            tick_nx  = '0;
                            wait_nx  = '0;
                            state_nx = FETCH;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule
